// File: rtl/seg_shift_pkg.sv
// Shared constants for the segment/LEDR shift datapath and its sequencer:
// speed range, shift direction encoding and HEX digit glyphs.
package seg_shift_pkg;

    localparam int NUM_SPEEDS = 10;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Active-low {g,f,e,d,c,b,a} glyphs
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] speed_glyph(input logic [3:0] level);
        case (level)
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            4'd10:   return SEG_A;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises an active-low push button, requires its level to be stable for
// DEBOUNCE_CYCLES cycles, and emits a one-cycle pulse on each accepted press.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             key_meta;
    logic             key_sync;
    logic             key_stable;
    logic [CNT_W-1:0] stable_cnt;
    logic             settled;

    // The synchronised level has differed from the accepted one long enough.
    assign settled = (key_sync != key_stable) &&
                     (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_meta   <= 1'b1;
            key_sync   <= 1'b1;
            key_stable <= 1'b1;
            stable_cnt <= '0;
            press      <= 1'b0;
        end else begin
            key_meta <= key_n;
            key_sync <= key_meta;
            press    <= settled && !key_sync;
            if (key_sync == key_stable) begin
                stable_cnt <= '0;
            end else if (settled) begin
                key_stable <= key_sync;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Sequencer for the shift datapath: owns the speed level, generates the shift
// tick and registers a per-shift command decoded from the switches.
module shift_sequencer
    import seg_shift_pkg::*;
#(
    parameter int CLK_HZ          = 50000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       spd_up_n,
    input  logic       spd_down_n,
    input  logic [3:0] sw,
    output logic [3:0] speed,
    output logic [6:0] hex_speed,
    output logic       shift_en,
    output logic       shift_dir,
    output logic       fill_valid,
    output logic       fill_bit
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [3:0]       sw_meta;
    logic [3:0]       sw_sync;
    logic             up_press;
    logic             down_press;
    logic [3:0]       speed_q;
    logic [3:0]       speed_d;
    logic [CNT_W-1:0] tick_cnt;
    logic [31:0]      period;
    logic             tick;
    logic             shift_req;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk   (CLOCK_50),
        .reset (reset),
        .key_n (spd_up_n),
        .press (up_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clk   (CLOCK_50),
        .reset (reset),
        .key_n (spd_down_n),
        .press (down_press)
    );

    // A period that shifts down to zero degenerates to a tick every cycle.
    assign period    = 32'(CLK_HZ) >> (speed_q - 4'd1);
    assign tick      = (32'(tick_cnt) + 32'd1) >= period;
    assign shift_req = sw_sync[0] | sw_sync[1];

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        speed_d = speed_q;
        if (up_press && !down_press && speed_q < 4'(NUM_SPEEDS)) begin
            speed_d = speed_q + 4'd1;
        end else if (down_press && !up_press && speed_q > 4'd1) begin
            speed_d = speed_q - 4'd1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sw_meta    <= '0;
            sw_sync    <= '0;
            speed_q    <= 4'd1;
            tick_cnt   <= '0;
            shift_en   <= 1'b0;
            shift_dir  <= DIR_RIGHT;
            fill_valid <= 1'b0;
            fill_bit   <= 1'b0;
        end else begin
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            speed_q  <= speed_d;
            if (speed_d != speed_q || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            shift_en <= tick && shift_req;
            // Command fields only move on a real strobe and hold otherwise.
            if (tick && shift_req) begin
                shift_dir  <= sw_sync[0] ? DIR_RIGHT : DIR_LEFT;
                fill_valid <= sw_sync[2] | sw_sync[3];
                fill_bit   <= sw_sync[2];
            end
        end
    end

    assign speed     = speed_q;
    assign hex_speed = speed_glyph(speed_q);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: a CLK_HZ=16 instance for timing and
// decode, and a CLK_HZ=1024 instance sharing its inputs for the top speeds.
module tb_shift_sequencer;

    localparam logic [6:0] GLYPH [10] = '{
        7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
        7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000
    };

    logic       clk = 1'b0;
    logic       reset;
    logic       spd_up_n;
    logic       spd_down_n;
    logic [3:0] sw;

    logic [3:0] speed,      speed_f;
    logic [6:0] hex_speed,  hex_speed_f;
    logic       shift_en,   shift_en_f;
    logic       shift_dir,  shift_dir_f;
    logic       fill_valid, fill_valid_f;
    logic       fill_bit,   fill_bit_f;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.CLK_HZ(16), .DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .spd_up_n   (spd_up_n),
        .spd_down_n (spd_down_n),
        .sw         (sw),
        .speed      (speed),
        .hex_speed  (hex_speed),
        .shift_en   (shift_en),
        .shift_dir  (shift_dir),
        .fill_valid (fill_valid),
        .fill_bit   (fill_bit)
    );

    shift_sequencer #(.CLK_HZ(1024), .DEBOUNCE_CYCLES(4)) dut_fast (
        .CLOCK_50   (clk),
        .reset      (reset),
        .spd_up_n   (spd_up_n),
        .spd_down_n (spd_down_n),
        .sw         (sw),
        .speed      (speed_f),
        .hex_speed  (hex_speed_f),
        .shift_en   (shift_en_f),
        .shift_dir  (shift_dir_f),
        .fill_valid (fill_valid_f),
        .fill_bit   (fill_bit_f)
    );

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                      tag, actual, actual, expected, expected);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Cycles until the selected instance strobes, capped at 200.
    task automatic wait_en(input bit fast, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (((fast ? shift_en_f : shift_en) == 1'b0) && n < 200);
    endtask

    task automatic press_up();
        spd_up_n = 1'b0;
        step(8);
        spd_up_n = 1'b1;
        step(8);
    endtask

    task automatic press_down();
        spd_down_n = 1'b0;
        step(8);
        spd_down_n = 1'b1;
        step(8);
    endtask

    initial begin
        int n;
        int cnt;
        int exp_spd;

        reset      = 1'b1;
        spd_up_n   = 1'b1;
        spd_down_n = 1'b1;
        sw         = 4'b0001;
        step(3);
        check("reset speed",      speed,      1);
        check("reset hex",        hex_speed,  7'b1111001);
        check("reset shift_en",   shift_en,   0);
        check("reset shift_dir",  shift_dir,  0);
        check("reset fill_valid", fill_valid, 0);
        check("reset fill_bit",   fill_bit,   0);

        // Speed 1: first strobe 16 cycles after reset, then every 16.
        reset = 1'b0;
        wait_en(1'b0, n);
        check("first strobe latency", n, 16);
        wait_en(1'b0, n);
        check("speed1 period", n, 16);
        check("speed1 dir right", shift_dir, 0);
        check("speed1 circular", fill_valid, 0);

        // One held press: speed changes exactly 7 cycles after the raw edge.
        spd_up_n = 1'b0;
        step(6);
        check("up before latency", speed, 1);
        step(1);
        check("up at latency", speed, 2);
        check("up hex", hex_speed, 7'b0100100);
        wait_en(1'b0, n);
        check("speed2 first strobe after clear", n, 8);
        wait_en(1'b0, n);
        check("speed2 period", n, 8);
        step(50);
        check("held button single event", speed, 2);
        spd_up_n = 1'b1;
        step(10);
        check("release no event", speed, 2);

        // Walk up to saturation, then back down.
        for (int i = 1; i <= 12; i++) begin
            press_up();
            exp_spd = (2 + i > 10) ? 10 : 2 + i;
            check($sformatf("up%0d speed", i), speed_f, exp_spd);
            check($sformatf("up%0d hex", i), hex_speed_f, GLYPH[exp_spd-1]);
        end
        check("slow instance saturates", speed, 10);
        wait_en(1'b1, n);
        wait_en(1'b1, n);
        check("speed10 period", n, 2);
        for (int i = 1; i <= 12; i++) begin
            press_down();
            exp_spd = (10 - i < 1) ? 1 : 10 - i;
            check($sformatf("down%0d speed", i), speed, exp_spd);
            check($sformatf("down%0d hex", i), hex_speed, GLYPH[exp_spd-1]);
        end

        // Direction decode at speed 1.
        sw = 4'b0011;
        wait_en(1'b0, n);
        wait_en(1'b0, n);
        check("sw0011 strobe period", n, 16);
        check("sw0011 dir right", shift_dir, 0);
        sw = 4'b0010;
        wait_en(1'b0, n);
        wait_en(1'b0, n);
        check("sw0010 strobe period", n, 16);
        check("sw0010 dir left", shift_dir, 1);
        sw = 4'b0000;
        step(3);
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (shift_en) cnt++;
        end
        check("stall no strobes", cnt, 0);
        check("stall holds dir", shift_dir, 1);

        // Fill decode.
        sw = 4'b1101;
        wait_en(1'b0, n);
        wait_en(1'b0, n);
        check("sw1101 fill_valid", fill_valid, 1);
        check("sw1101 fill_bit", fill_bit, 1);
        check("sw1101 dir", shift_dir, 0);
        sw = 4'b1001;
        wait_en(1'b0, n);
        wait_en(1'b0, n);
        check("sw1001 fill_valid", fill_valid, 1);
        check("sw1001 fill_bit", fill_bit, 0);
        sw = 4'b0001;
        wait_en(1'b0, n);
        wait_en(1'b0, n);
        check("sw0001 fill_valid", fill_valid, 0);

        // Coincident up and down presses cancel.
        press_up();
        check("pre-coincident speed", speed, 2);
        spd_up_n   = 1'b0;
        spd_down_n = 1'b0;
        step(10);
        check("coincident unchanged", speed, 2);
        spd_up_n   = 1'b1;
        spd_down_n = 1'b1;
        step(10);
        check("coincident release", speed, 2);

        // Reset mid-debounce discards the pending press.
        spd_up_n = 1'b0;
        step(4);
        reset = 1'b1;
        step(1);
        check("mid-debounce reset speed", speed, 1);
        check("mid-debounce reset hex", hex_speed, 7'b1111001);
        check("mid-debounce reset shift_en", shift_en, 0);
        spd_up_n = 1'b1;
        reset    = 1'b0;
        step(20);
        check("no event after reset", speed, 1);
        wait_en(1'b0, n);
        wait_en(1'b0, n);
        check("period after reset", n, 16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
